// File: rtl/cla_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : cla_nibble_serial_adder
// Description : WIDTH-bit add/subtract through one shared 4-bit carry-
//               lookahead slice, one nibble per clock, LSB nibble first.
//               Operand intake and result delivery use valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIB  = WIDTH / 4;
    // Keep the index at least one bit wide so WIDTH=4 still elaborates.
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] c_LAST = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_busy;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;      // already inverted for subtract
    logic              r_carry;
    logic [IDXW-1:0]   r_idx;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_ovf;

    logic [3:0]        w_a_nib;
    logic [3:0]        w_b_nib;
    logic [3:0]        w_g;
    logic [3:0]        w_p;
    logic [4:0]        w_c;
    logic [3:0]        w_s;
    logic              w_last;

    // Nibble selection for the current step.
    assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
    assign w_b_nib = r_b[{r_idx, 2'b00} +: 4];
    assign w_last  = (r_idx == c_LAST);

    // Four-bit carry-lookahead slice: every carry is formed directly from
    // generate/propagate terms and the registered carry-in.
    always_comb begin
        w_g    = w_a_nib & w_b_nib;
        w_p    = w_a_nib ^ w_b_nib;
        w_c[0] = r_carry;
        w_c[1] = w_g[0] | (w_p[0] & r_carry);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & r_carry);
        w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
        w_s    = w_p ^ w_c[3:0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake/status decode.
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                w_busy      = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, per-nibble accumulation and final flag update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub | cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                    end
                end
                S_RUN: begin
                    r_sum[{r_idx, 2'b00} +: 4] <= w_s;
                    r_carry                    <= w_c[4];
                    if (w_last) begin
                        r_cout <= w_c[4];
                        r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s[3] != r_a[WIDTH-1]);
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // in_ready is suppressed while reset is held.
    assign in_ready  = w_in_ready & rst_n;
    assign out_valid = w_out_valid;
    assign busy      = w_busy;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cla_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_nibble_serial_adder
// Description : Self-checking bench for cla_nibble_serial_adder (WIDTH=16).
//               Expected results come from a behavioural model and are held
//               in a scoreboard queue until the DUT presents its result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
    } vec_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    cla_nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: push the architectural result for the given operands.
    task automatic push_expected(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                                 input logic tcin, input logic tsub);
        logic [WIDTH-1:0] bp;
        logic [WIDTH:0]   full;
        exp_t             e;
        bp     = tsub ? ~tb_ : tb_;
        full   = {1'b0, ta} + {1'b0, bp} + {{WIDTH{1'b0}}, (tsub ? 1'b1 : tcin)};
        e.sum  = full[WIDTH-1:0];
        e.cout = full[WIDTH];
        e.ovf  = (ta[WIDTH-1] == bp[WIDTH-1]) && (full[WIDTH-1] != ta[WIDTH-1]);
        sb.push_back(e);
    endtask

    // Wait for out_valid (bounded), counting cycles and cycles with in_ready high.
    task automatic wait_done(output int lat, output int ir_bad);
        lat    = 0;
        ir_bad = 0;
        while (!out_valid && lat < 20) begin
            if (in_ready) ir_bad++;
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    // Offer one operation, record its expectation, wait for the result.
    task automatic run_op(input vec_t v, output int lat, output int ir_bad);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        a        = v.a;
        b        = v.b;
        cin      = v.cin;
        sub      = v.sub;
        in_valid = 1'b1;
        push_expected(v.a, v.b, v.cin, v.sub);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        cin      = 1'($urandom);
        sub      = 1'($urandom);
        wait_done(lat, ir_bad);
    endtask

    task automatic complete_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: out_valid=%b busy=%b sum=%h cout=%b ovf=%b, required all 0",
                     out_valid, busy, sum, cout, ovf);
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic test_add();
        vec_t v[4];
        exp_t e;
        int   lat, irb;
        v[0] = '{a: 16'h1234, b: 16'h4321, cin: 1'b0, sub: 1'b0};
        v[1] = '{a: 16'hA5A5, b: 16'h1357, cin: 1'b1, sub: 1'b0};
        v[2] = '{a: 16'($urandom), b: 16'($urandom), cin: 1'b0, sub: 1'b0};
        v[3] = '{a: 16'($urandom), b: 16'($urandom), cin: 1'b1, sub: 1'b1};
        for (int i = 0; i < 4; i++) begin
            run_op(v[i], lat, irb);
            e = sb.pop_front();
            n_tests++;
            if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
                n_fail++;
                $display("FAIL add[%0d]: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                         i, sum, cout, ovf, e.sum, e.cout, e.ovf);
            end
            n_tests++;
            if (lat !== NIB || irb !== 0) begin
                n_fail++;
                $display("FAIL add_latency[%0d]: got lat=%0d in_ready_cycles=%0d, required lat=%0d in_ready_cycles=0",
                         i, lat, irb, NIB);
            end
            complete_op();
            n_tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || sum !== e.sum) begin
                n_fail++;
                $display("FAIL add_handshake[%0d]: out_valid=%b in_ready=%b busy=%b sum=%h, required 0 1 0 %h",
                         i, out_valid, in_ready, busy, sum, e.sum);
            end
        end
    endtask

    task automatic test_carry();
        vec_t v[2];
        exp_t e;
        int   lat, irb;
        v[0] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sub: 1'b0};
        v[1] = '{a: 16'h0FFF, b: 16'h0000, cin: 1'b1, sub: 1'b0};
        for (int i = 0; i < 2; i++) begin
            run_op(v[i], lat, irb);
            e = sb.pop_front();
            n_tests++;
            if (lat !== NIB || sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
                n_fail++;
                $display("FAIL carry[%0d]: got sum=%h cout=%b ovf=%b lat=%0d, required sum=%h cout=%b ovf=%b lat=%0d",
                         i, sum, cout, ovf, lat, e.sum, e.cout, e.ovf, NIB);
            end
            complete_op();
        end
    endtask

    task automatic test_overflow();
        vec_t v[2];
        exp_t e;
        int   lat, irb;
        v[0] = '{a: 16'h7FFF, b: 16'h0001, cin: 1'b0, sub: 1'b0};
        v[1] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, sub: 1'b0};
        for (int i = 0; i < 2; i++) begin
            run_op(v[i], lat, irb);
            e = sb.pop_front();
            n_tests++;
            if (lat !== NIB || sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
                n_fail++;
                $display("FAIL overflow[%0d]: got sum=%h cout=%b ovf=%b lat=%0d, required sum=%h cout=%b ovf=%b lat=%0d",
                         i, sum, cout, ovf, lat, e.sum, e.cout, e.ovf, NIB);
            end
            complete_op();
        end
    endtask

    task automatic test_sub();
        vec_t v[3];
        exp_t e;
        int   lat, irb;
        v[0] = '{a: 16'h0005, b: 16'h0007, cin: 1'b1, sub: 1'b1};
        v[1] = '{a: 16'h8000, b: 16'h0001, cin: 1'b1, sub: 1'b1};
        v[2] = '{a: 16'h1234, b: 16'h1234, cin: 1'b0, sub: 1'b1};
        for (int i = 0; i < 3; i++) begin
            run_op(v[i], lat, irb);
            e = sb.pop_front();
            n_tests++;
            if (lat !== NIB || sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
                n_fail++;
                $display("FAIL sub[%0d]: got sum=%h cout=%b ovf=%b lat=%0d, required sum=%h cout=%b ovf=%b lat=%0d",
                         i, sum, cout, ovf, lat, e.sum, e.cout, e.ovf, NIB);
            end
            complete_op();
        end
    endtask

    task automatic test_backpressure();
        vec_t             v;
        exp_t             e;
        int               lat, irb;
        logic [WIDTH-1:0] hold_sum;
        logic             hold_c, hold_o;
        int               bad;
        v = '{a: 16'h1111, b: 16'h2222, cin: 1'b0, sub: 1'b0};
        run_op(v, lat, irb);
        e = sb.pop_front();
        n_tests++;
        if (lat !== NIB || sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
            n_fail++;
            $display("FAIL bp_first: got sum=%h cout=%b ovf=%b lat=%0d, required sum=%h cout=%b ovf=%b lat=%0d",
                     sum, cout, ovf, lat, e.sum, e.cout, e.ovf, NIB);
        end
        hold_sum = sum;
        hold_c   = cout;
        hold_o   = ovf;
        bad      = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            sub = i[0];
            @(posedge clk); #1;
            if (sum !== hold_sum || cout !== hold_c || ovf !== hold_o || in_ready !== 1'b0 || out_valid !== 1'b1)
                bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL bp_hold: got %0d unstable cycles, required 0", bad);
        end
        a   = 16'h0010;
        b   = 16'h0020;
        cin = 1'b0;
        sub = 1'b0;
        push_expected(16'h0010, 16'h0020, 1'b0, 1'b0);
        complete_op();
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== hold_sum) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b busy=%b sum=%h, required 1 0 0 %h",
                     in_ready, out_valid, busy, sum, hold_sum);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accept: busy=%b in_ready=%b, required 1 0", busy, in_ready);
        end
        wait_done(lat, irb);
        e = sb.pop_front();
        n_tests++;
        if (lat !== NIB || sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
            n_fail++;
            $display("FAIL bp_pending: got sum=%h cout=%b ovf=%b lat=%0d, required sum=%h cout=%b ovf=%b lat=%0d",
                     sum, cout, ovf, lat, e.sum, e.cout, e.ovf, NIB);
        end
        complete_op();
    endtask

    task automatic test_async_reset();
        vec_t v;
        exp_t e;
        int   lat, irb;
        a        = 16'h1234;
        b        = 16'h1111;
        cin      = 1'b1;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        n_tests++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_midrun: busy=%b out_valid=%b, required 1 0", busy, out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_clear: out_valid=%b busy=%b sum=%h cout=%b ovf=%b, required all 0",
                     out_valid, busy, sum, cout, ovf);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        v = '{a: 16'h0001, b: 16'h0001, cin: 1'b0, sub: 1'b0};
        run_op(v, lat, irb);
        e = sb.pop_front();
        n_tests++;
        if (lat !== NIB || sum !== 16'h0002 || sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
            n_fail++;
            $display("FAIL arst_after: got sum=%h cout=%b ovf=%b lat=%0d, required sum=%h cout=%b ovf=%b lat=%0d",
                     sum, cout, ovf, lat, e.sum, e.cout, e.ovf, NIB);
        end
        complete_op();
    endtask

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        rst_n     = 1'b0;
        test_reset();
        test_add();
        test_carry();
        test_overflow();
        test_sub();
        test_backpressure();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
